vending_machine_gen: RTL and testbench
======================================

Name: vending_machine_gen

Overview:
- Parametrised next-generation vending controller: accepts a coin batch and an item request, checks price and per-item stock, then returns greedy change one coin per cycle from a finite coin store.
- Generalises the earlier fixed 3-item machine with parametrised item count, prices, coin-store depth and value width; adds per-item stock, sold-out refusal and an idle-time coin/stock refill.
- Sits behind the front-panel decoder; its outputs feed the dispenser and the formal property harness.

Parameters:
- NUM_ITEM, 3, number of sellable items; item codes 1..NUM_ITEM, code 0 means none.
- ITEM_COST, {8'd22,8'd15,8'd8}, packed NUM_ITEM*8-bit price table; item k uses slice k-1.
- IN_W, 2, width of each per-denomination coin-in count.
- CNT_W, 3, width of each coin-store counter and each coin-out count; saturates at 2^CNT_W-1.
- INIT_CNT, 2, coin-store value per denomination after reset or refill.
- STOCK_W, 3, width of each per-item stock counter.
- INIT_STOCK, 3, per-item stock after reset or refill.
- VAL_W, 10, width of all money values; must hold 66*(2^IN_W-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coin_in  in  4*IN_W  coin counts, slices [50,10,5,1] from MSB.
- item_in  in  ITEM_W (= $clog2(NUM_ITEM+1))  requested item; 0 = none.
- refill  in  1  reload coin store and stock; honoured only in ON.
- coin_out  out  4*CNT_W  change coins, slices [50,10,5,1] from MSB.
- item_out  out  ITEM_W  dispensed item; 0 = none or refund.
- service_out  out  2  00 OFF, 01 ON, 10 BUSY.
- sold_out  out  NUM_ITEM  bit k-1 set when item k stock is 0.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: coin_out 0, item_out 0, service_out ON, all store counters INIT_CNT, all stock INIT_STOCK, internal values 0, denomination pointer at 50, check flag 0.
- ON:
  - If refill is high, reload the store and stock, and ignore item_in that cycle.
  - Else, if item_in is nonzero and <= NUM_ITEM, latch it, clear coin_out, and go to BUSY.
  - On that latch edge: store[d] += coin_in[d], saturating at 2^CNT_W-1, with excess coins kept (not refunded); input_value = 50a+10b+5c+d.
  - An out-of-range item_in is treated as 0.
- BUSY, check cycle (flag=0):
  - If input_value < cost, or the item's stock is 0: service_value = input_value and item_out = 0.
  - Otherwise: service_value = input_value - cost.
  - In both cases set flag=1 and point at 50.
- BUSY, dispense cycles, one action per cycle:
  - If service_value >= denomination value and store[d] > 0: coin_out[d]++, store[d]--, service_value -= value.
  - Otherwise advance the pointer 50→10→5→1.
  - At denomination 1 with service_value = 0: go to OFF and decrement stock[item_out] if item_out is nonzero.
  - At denomination 1 with service_value > 0 and store[1] = 0 (rollback): store[d] += coin_out[d], coin_out = 0, item_out = 0, service_value = input_value, pointer to 50, stay in BUSY, and retry as a refund.
  - A refund retry whose store is also insufficient repeats indefinitely; this is a known stuck case and is flagged by the property harness.
- OFF: exactly one cycle; coin_out and item_out hold the result; then clear both and go to ON.
- Latency: an ON request reaches OFF after 1 + 1 + (coins issued) + (pointer advances) + 1 cycles at minimum.
- Reset mid-BUSY aborts the transaction without refund; all state returns to reset values.
- sold_out is combinational from the stock counters.

Optional Feature:
- Macro VENDING_PROP_EN.
- When defined, add outputs p_refund and p_item[NUM_ITEM], all combinational and high only on a violation in OFF:
  - p_refund: item_out=0 and change != input_value.
  - p_item[k-1]: item_out=k and change+cost != input_value.
- Change is computed as 50a+10b+5c+d over coin_out at VAL_W.
- When undefined, these ports and their logic are absent.

Decomposition:
- Package vending_pkg: service encodings, denomination indices and values (50,10,5,1), and a function money_value(counts) returning VAL_W.
- One sub-module, vending_coin_store: four saturating CNT_W counters with load, increment-by-batch, decrement and add-back ports.

Test Plan:
- Reset, coin_in 50:0,10:1,5:0,1:0, item 1 (cost 8) -> OFF with item_out=1, coin_out 1-coin=2, stock[0]=2.
- 50:1, item 3 (cost 22) -> change 28 = 10×2, 5×1, 1×3; store[1]=2 after reset, so rollback occurs -> item_out=0, refund coin_out 50=1.
- 10:1, item 2 (cost 15) -> insufficient funds; item_out=0, coin_out 10=1.
- Buy item 1 three times with exact 5+1+1+1 -> sold_out[0]=1; a fourth request -> full refund, item_out=0.
- Assert refill in ON with item_in=2 -> counters reload, no BUSY entry; then pulse reset mid-BUSY -> service_out=ON next cycle.
- Send 1:3 repeatedly until store[1] reaches 7 -> saturation holds at 7; with VENDING_PROP_EN, p_refund and p_item stay 0 for all cases.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared encodings and money helpers for vending_machine_gen and its coin store.
package vending_pkg;

    typedef enum logic [1:0] {
        SVC_OFF  = 2'b00,
        SVC_ON   = 2'b01,
        SVC_BUSY = 2'b10
    } svc_e;

    // Denomination index equals its slice position in coin_in/coin_out (3 = MSB = 50).
    typedef enum logic [1:0] {
        DEN_1  = 2'd0,
        DEN_5  = 2'd1,
        DEN_10 = 2'd2,
        DEN_50 = 2'd3
    } den_e;

    localparam int unsigned NUM_DEN   = 4;
    localparam int unsigned MONEY_W   = 16;
    localparam int unsigned CNT_MAX_W = 8;

    typedef logic [MONEY_W-1:0]                   money_t;
    typedef logic [NUM_DEN-1:0][CNT_MAX_W-1:0]    counts_t;

    function automatic money_t denom_value(den_e d);
        case (d)
            DEN_50:  return money_t'(50);
            DEN_10:  return money_t'(10);
            DEN_5:   return money_t'(5);
            default: return money_t'(1);
        endcase
    endfunction

    function automatic money_t money_value(counts_t counts);
        money_t sum;
        sum = '0;
        for (int unsigned d = 0; d < NUM_DEN; d++)
            sum = sum + denom_value(den_e'(2'(d))) * money_t'(counts[d]);
        return sum;
    endfunction

endpackage

// File: rtl/vending_coin_store.sv
// Four saturating per-denomination coin counters: reload, batch add, add-back and single decrement.
module vending_coin_store
    import vending_pkg::*;
#(
    parameter int unsigned IN_W     = 2,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned INIT_CNT = 2
)(
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_load,
    input  logic                              i_add_en,
    input  logic [NUM_DEN*IN_W-1:0]           i_add_batch,
    input  logic                              i_back_en,
    input  logic [NUM_DEN-1:0][CNT_W-1:0]     i_back_cnt,
    input  logic                              i_dec_en,
    input  den_e                              i_dec_sel,
    output logic [NUM_DEN-1:0][CNT_W-1:0]     o_cnt
);

    logic [NUM_DEN-1:0][CNT_W-1:0] r_cnt;

    function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] a, logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge i_clk) begin
        for (int unsigned d = 0; d < NUM_DEN; d++) begin
            if (i_reset || i_load)
                r_cnt[d] <= CNT_W'(INIT_CNT);
            else if (i_add_en)
                r_cnt[d] <= sat_add(r_cnt[d], CNT_W'(i_add_batch[d*IN_W +: IN_W]));
            else if (i_back_en)
                r_cnt[d] <= sat_add(r_cnt[d], i_back_cnt[d]);
            else if (i_dec_en && (i_dec_sel == den_e'(2'(d))) && (r_cnt[d] != '0))
                r_cnt[d] <= r_cnt[d] - CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: price/stock check, then greedy change one coin per cycle.
// Optional property outputs p_refund/p_item are built when VENDING_PROP_EN is defined.
module vending_machine_gen
    import vending_pkg::*;
#(
    parameter int unsigned              NUM_ITEM   = 3,
    parameter logic [NUM_ITEM*8-1:0]    ITEM_COST  = {8'd22, 8'd15, 8'd8},
    parameter int unsigned              IN_W       = 2,
    parameter int unsigned              CNT_W      = 3,
    parameter int unsigned              INIT_CNT   = 2,
    parameter int unsigned              STOCK_W    = 3,
    parameter int unsigned              INIT_STOCK = 3,
    parameter int unsigned              VAL_W      = 10,
    localparam int unsigned             ITEM_W     = $clog2(NUM_ITEM + 1)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*IN_W-1:0]       coin_in,
    input  logic [ITEM_W-1:0]       item_in,
    input  logic                    refill,
    output logic [4*CNT_W-1:0]      coin_out,
    output logic [ITEM_W-1:0]       item_out,
    output logic [1:0]              service_out,
    output logic [NUM_ITEM-1:0]     sold_out
`ifdef VENDING_PROP_EN
    ,
    output logic                    p_refund,
    output logic [NUM_ITEM-1:0]     p_item
`endif
);

    svc_e                               r_state, w_state_nxt;
    logic [ITEM_W-1:0]                  r_item, w_item_nxt;
    logic [NUM_DEN-1:0][CNT_W-1:0]      r_coin, w_coin_nxt;
    logic [VAL_W-1:0]                   r_in_val, w_in_val_nxt;
    logic [VAL_W-1:0]                   r_svc_val, w_svc_val_nxt;
    den_e                               r_ptr, w_ptr_nxt;
    logic                               r_flag, w_flag_nxt;
    logic [NUM_ITEM-1:0][STOCK_W-1:0]   r_stock, w_stock_nxt;

    logic                               w_st_load, w_st_add, w_st_back, w_st_dec;
    logic [NUM_DEN-1:0][CNT_W-1:0]      w_store;
    counts_t                            w_in_counts;
    logic [VAL_W-1:0]                   w_in_money;
    logic [VAL_W-1:0]                   w_cost;
    logic [STOCK_W-1:0]                 w_stock_sel;
    logic [VAL_W-1:0]                   w_den_val;
    logic [CNT_W-1:0]                   w_den_cnt;
    logic                               w_item_ok;

    vending_coin_store #(
        .IN_W     (IN_W),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_store (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_load      (w_st_load),
        .i_add_en    (w_st_add),
        .i_add_batch (coin_in),
        .i_back_en   (w_st_back),
        .i_back_cnt  (r_coin),
        .i_dec_en    (w_st_dec),
        .i_dec_sel   (r_ptr),
        .o_cnt       (w_store)
    );

    always_comb begin
        w_in_counts = '0;
        for (int unsigned d = 0; d < NUM_DEN; d++)
            w_in_counts[d] = CNT_MAX_W'(coin_in[d*IN_W +: IN_W]);
    end

    assign w_in_money = VAL_W'(money_value(w_in_counts));
    assign w_item_ok  = (item_in != '0) && (item_in <= ITEM_W'(NUM_ITEM));
    assign w_den_val  = VAL_W'(denom_value(r_ptr));
    assign w_den_cnt  = w_store[r_ptr];

    always_comb begin
        w_cost      = '0;
        w_stock_sel = '0;
        for (int unsigned k = 0; k < NUM_ITEM; k++) begin
            if (r_item == ITEM_W'(k + 1)) begin
                w_cost      = VAL_W'(ITEM_COST[k*8 +: 8]);
                w_stock_sel = r_stock[k];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_item_nxt    = r_item;
        w_coin_nxt    = r_coin;
        w_in_val_nxt  = r_in_val;
        w_svc_val_nxt = r_svc_val;
        w_ptr_nxt     = r_ptr;
        w_flag_nxt    = r_flag;
        w_stock_nxt   = r_stock;
        w_st_load     = 1'b0;
        w_st_add      = 1'b0;
        w_st_back     = 1'b0;
        w_st_dec      = 1'b0;

        case (r_state)
            SVC_ON: begin
                if (refill) begin
                    w_st_load = 1'b1;
                    for (int unsigned k = 0; k < NUM_ITEM; k++)
                        w_stock_nxt[k] = STOCK_W'(INIT_STOCK);
                end else if (w_item_ok) begin
                    w_item_nxt   = item_in;
                    w_coin_nxt   = '0;
                    w_st_add     = 1'b1;
                    w_in_val_nxt = w_in_money;
                    w_flag_nxt   = 1'b0;
                    w_state_nxt  = SVC_BUSY;
                end
            end

            SVC_BUSY: begin
                if (!r_flag) begin
                    if ((r_in_val < w_cost) || (w_stock_sel == '0)) begin
                        w_svc_val_nxt = r_in_val;
                        w_item_nxt    = '0;
                    end else begin
                        w_svc_val_nxt = r_in_val - w_cost;
                    end
                    w_flag_nxt = 1'b1;
                    w_ptr_nxt  = DEN_50;
                end else if ((r_svc_val >= w_den_val) && (w_den_cnt != '0)) begin
                    w_coin_nxt[r_ptr] = r_coin[r_ptr] + CNT_W'(1);
                    w_st_dec          = 1'b1;
                    w_svc_val_nxt     = r_svc_val - w_den_val;
                end else if (r_ptr != DEN_1) begin
                    case (r_ptr)
                        DEN_50:  w_ptr_nxt = DEN_10;
                        DEN_10:  w_ptr_nxt = DEN_5;
                        default: w_ptr_nxt = DEN_1;
                    endcase
                end else if (r_svc_val == '0) begin
                    w_state_nxt = SVC_OFF;
                    for (int unsigned k = 0; k < NUM_ITEM; k++)
                        if (r_item == ITEM_W'(k + 1))
                            w_stock_nxt[k] = r_stock[k] - STOCK_W'(1);
                end else begin
                    // Store cannot finish the change: return issued coins and retry the whole input as a refund.
                    w_st_back     = 1'b1;
                    w_coin_nxt    = '0;
                    w_item_nxt    = '0;
                    w_svc_val_nxt = r_in_val;
                    w_ptr_nxt     = DEN_50;
                end
            end

            SVC_OFF: begin
                w_coin_nxt  = '0;
                w_item_nxt  = '0;
                w_state_nxt = SVC_ON;
            end

            default: w_state_nxt = SVC_ON;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= SVC_ON;
            r_item    <= '0;
            r_coin    <= '0;
            r_in_val  <= '0;
            r_svc_val <= '0;
            r_ptr     <= DEN_50;
            r_flag    <= 1'b0;
            for (int unsigned k = 0; k < NUM_ITEM; k++)
                r_stock[k] <= STOCK_W'(INIT_STOCK);
        end else begin
            r_state   <= w_state_nxt;
            r_item    <= w_item_nxt;
            r_coin    <= w_coin_nxt;
            r_in_val  <= w_in_val_nxt;
            r_svc_val <= w_svc_val_nxt;
            r_ptr     <= w_ptr_nxt;
            r_flag    <= w_flag_nxt;
            r_stock   <= w_stock_nxt;
        end
    end

    assign coin_out    = r_coin;
    assign item_out    = r_item;
    assign service_out = r_state;

    always_comb begin
        sold_out = '0;
        for (int unsigned k = 0; k < NUM_ITEM; k++)
            sold_out[k] = (r_stock[k] == '0);
    end

`ifdef VENDING_PROP_EN
    counts_t            w_chg_counts;
    logic [VAL_W-1:0]   w_change;

    always_comb begin
        w_chg_counts = '0;
        for (int unsigned d = 0; d < NUM_DEN; d++)
            w_chg_counts[d] = CNT_MAX_W'(r_coin[d]);
    end

    assign w_change = VAL_W'(money_value(w_chg_counts));

    always_comb begin
        p_refund = (r_state == SVC_OFF) && (r_item == '0) && (w_change != r_in_val);
        p_item   = '0;
        for (int unsigned k = 0; k < NUM_ITEM; k++)
            p_item[k] = (r_state == SVC_OFF) && (r_item == ITEM_W'(k + 1)) &&
                        ((w_change + VAL_W'(ITEM_COST[k*8 +: 8])) != r_in_val);
    end
`endif

endmodule

// File: tb/tb_vending_machine_gen.sv
// Randomised scoreboard bench for vending_machine_gen against a greedy-change reference model.
module tb_vending_machine_gen;

    localparam logic [1:0] S_OFF  = 2'b00;
    localparam logic [1:0] S_ON   = 2'b01;
    localparam logic [1:0] S_BUSY = 2'b10;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        refill  = 1'b0;
    logic [7:0]  coin_in = '0;
    logic [1:0]  item_in = '0;
    logic [11:0] coin_out;
    logic [1:0]  item_out;
    logic [1:0]  service_out;
    logic [2:0]  sold_out;
`ifdef VENDING_PROP_EN
    logic        p_refund;
    logic [2:0]  p_item;
`endif

    typedef struct packed {
        logic [1:0]  item;
        logic [11:0] coins;
        logic [7:0]  busy;
        logic [2:0]  sold;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    int st[4];
    int stock[3];
    int g_out[4];
    int dval[4] = '{1, 5, 10, 50};
    int cost[3] = '{8, 15, 22};

    vending_machine_gen #(
        .NUM_ITEM   (3),
        .ITEM_COST  ({8'd22, 8'd15, 8'd8}),
        .IN_W       (2),
        .CNT_W      (3),
        .INIT_CNT   (2),
        .STOCK_W    (3),
        .INIT_STOCK (3),
        .VAL_W      (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_in     (coin_in),
        .item_in     (item_in),
        .refill      (refill),
        .coin_out    (coin_out),
        .item_out    (item_out),
        .service_out (service_out),
        .sold_out    (sold_out)
`ifdef VENDING_PROP_EN
        ,
        .p_refund    (p_refund),
        .p_item      (p_item)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 4; d++) st[d] = 2;
        for (int k = 0; k < 3; k++) stock[k] = 3;
    endfunction

    // Greedy change from the current model store; fills g_out, returns the amount left unpaid.
    function automatic int greedy(input int amount);
        int left;
        left = amount;
        for (int d = 3; d >= 0; d--) begin
            g_out[d] = (left / dval[d] < st[d]) ? left / dval[d] : st[d];
            left -= g_out[d] * dval[d];
        end
        return left;
    endfunction

    function automatic exp_t model_txn(input int c50, input int c10, input int c5, input int c1, input int item);
        exp_t e;
        int   inc[4];
        int   value, change, left, n1, n2, busy, it;
        inc[0] = c1; inc[1] = c5; inc[2] = c10; inc[3] = c50;
        for (int d = 0; d < 4; d++)
            st[d] = (st[d] + inc[d] > 7) ? 7 : st[d] + inc[d];
        value = 50*c50 + 10*c10 + 5*c5 + c1;
        it = item;
        if (value < cost[item-1] || stock[item-1] == 0) begin
            it = 0;
            change = value;
        end else begin
            change = value - cost[item-1];
        end
        left = greedy(change);
        n1 = g_out[0] + g_out[1] + g_out[2] + g_out[3];
        if (left == 0) begin
            busy = n1 + 5;
        end else begin
            it = 0;
            left = greedy(value);
            n2 = g_out[0] + g_out[1] + g_out[2] + g_out[3];
            busy = n1 + 5 + n2 + 4;
        end
        for (int d = 0; d < 4; d++) st[d] -= g_out[d];
        if (it != 0) stock[it-1]--;
        e.item  = 2'(it);
        e.coins = {3'(g_out[3]), 3'(g_out[2]), 3'(g_out[1]), 3'(g_out[0])};
        e.busy  = 8'(busy);
        e.sold  = {stock[2] == 0, stock[1] == 0, stock[0] == 0};
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rst_service", service_out, S_ON);
        check("rst_coin_out", coin_out, 0);
        check("rst_item_out", item_out, 0);
        check("rst_sold_out", sold_out, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(service_out == S_ON && q.size() == 0)) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                total++;
                bad++;
                $display("FAIL idle_timeout: got service=%0b pending=%0d expected ON with none pending", service_out, q.size());
                q.delete();
                do_reset();
                return;
            end
        end
    endtask

    task automatic issue(input int c50, input int c10, input int c5, input int c1, input int item);
        wait_idle();
        coin_in = {2'(c50), 2'(c10), 2'(c5), 2'(c1)};
        item_in = 2'(item);
        q.push_back(model_txn(c50, c10, c5, c1, item));
        @(negedge clk);
        item_in = '0;
        coin_in = 8'($urandom);
    endtask

    task automatic issue_abort(input int c50, input int c10, input int c5, input int c1, input int item);
        exp_t dropped;
        issue(c50, c10, c5, c1, item);
        @(negedge clk);
        dropped = q.pop_back();
        do_reset();
    endtask

    task automatic do_refill(input int item);
        wait_idle();
        refill  = 1'b1;
        item_in = 2'(item);
        coin_in = 8'($urandom);
        model_reset();
        @(negedge clk);
        refill  = 1'b0;
        item_in = '0;
        check("refill_stays_on", service_out, S_ON);
        check("refill_sold_out", sold_out, 0);
    endtask

    task automatic idle_item0();
        wait_idle();
        item_in = '0;
        coin_in = 8'($urandom);
        @(negedge clk);
        check("item0_stays_on", service_out, S_ON);
    endtask

    // Monitor: pops one expectation per OFF cycle and checks the cycle after OFF.
    initial begin
        int   busy_cnt;
        bit   prev_off;
        exp_t e;
        busy_cnt = 0;
        prev_off = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_off) begin
                check("off_to_on", service_out, S_ON);
                check("off_clr_coin", coin_out, 0);
                check("off_clr_item", item_out, 0);
            end
            prev_off = 1'b0;
            case (service_out)
                S_BUSY: busy_cnt++;
                S_OFF: begin
                    prev_off = 1'b1;
                    check("off_expected", (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("item_out", item_out, e.item);
                        check("coin_out", coin_out, e.coins);
                        check("busy_cycles", busy_cnt, e.busy);
                        check("sold_out", sold_out, e.sold);
`ifdef VENDING_PROP_EN
                        check("p_refund", p_refund, 0);
                        check("p_item", p_item, 0);
`endif
                    end
                    busy_cnt = 0;
                end
                default: busy_cnt = 0;
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, a50, a10, a5, a1, it;
        do_reset();

        issue(0, 1, 0, 0, 1);
        wait_idle();
        do_reset();
        issue(1, 0, 0, 0, 3);
        wait_idle();
        do_reset();
        issue(0, 1, 0, 0, 2);
        wait_idle();
        do_reset();
        repeat (4) issue(0, 0, 1, 3, 1);
        do_refill(2);
        issue(0, 0, 1, 3, 1);
        issue_abort(0, 1, 0, 0, 1);
        issue(0, 1, 0, 3, 1);
        issue(0, 1, 0, 3, 1);
        issue(0, 1, 0, 3, 1);
        issue(0, 0, 0, 3, 2);
        issue(0, 2, 0, 0, 2);

        for (int n = 0; n < 160; n++) begin
            r = $urandom_range(19, 0);
            a50 = $urandom_range(3, 0);
            a10 = $urandom_range(3, 0);
            a5  = $urandom_range(3, 0);
            a1  = $urandom_range(3, 0);
            it  = $urandom_range(3, 1);
            if (r < 2)       do_refill($urandom_range(3, 0));
            else if (r == 2) idle_item0();
            else if (r == 3) issue_abort(a50, a10, a5, a1, it);
            else             issue(a50, a10, a5, a1, it);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
